// File: rtl/sfx_sequencer_if.sv
`default_nettype none
// ============================================================================
// sfx_sequencer_if : control/status bundle between game FSM and tone sequencer
// Rev 1.0
// ============================================================================
interface sfx_sequencer_if;
  logic       start;
  logic       stop;
  logic       pattern_sel;
  logic       loop_en;
  logic       speaker;
  logic       busy;
  logic       done;
  logic [4:0] step_idx;

  modport master (
    output start, stop, pattern_sel, loop_en,
    input  speaker, busy, done, step_idx
  );

  modport slave (
    input  start, stop, pattern_sel, loop_en,
    output speaker, busy, done, step_idx
  );
endinterface
`default_nettype wire

// File: rtl/sfx_sequencer.sv
`default_nettype none
// ============================================================================
// sfx_sequencer : triggerable square-wave tone sequencer (melody / punch)
// Rev 1.0
// ============================================================================
module sfx_sequencer #(
  parameter int unsigned STEP_CYCLES = 32'd5357141,
  parameter int unsigned GATE_CYCLES = 32'd3571428,
  parameter int unsigned DIV_SHIFT   = 32'd0,
  parameter int unsigned DIV_W       = 32'd19
) (
  input  logic           clk,
  input  logic           rst_n,
  sfx_sequencer_if.slave bus
);

  localparam int unsigned c_SCNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [c_SCNT_W-1:0] c_STEP_LAST = c_SCNT_W'(STEP_CYCLES - 1);

  localparam logic [3:0] c_REST = 4'd0;
  localparam logic [3:0] c_F3   = 4'd1;
  localparam logic [3:0] c_G3   = 4'd2;
  localparam logic [3:0] c_A3   = 4'd3;
  localparam logic [3:0] c_B3   = 4'd4;
  localparam logic [3:0] c_C4   = 4'd5;
  localparam logic [3:0] c_D4   = 4'd6;
  localparam logic [3:0] c_E4   = 4'd7;
  localparam logic [3:0] c_G4   = 4'd8;

  localparam logic [3:0] c_MELODY [32] = '{
    c_A3, c_A3, c_C4, c_A3, c_D4, c_A3, c_E4, c_D4,
    c_C4, c_C4, c_E4, c_C4, c_G4, c_C4, c_E4, c_C4,
    c_G3, c_G3, c_B3, c_G3, c_C4, c_G3, c_D4, c_C4,
    c_F3, c_F3, c_A3, c_F3, c_C4, c_F3, c_C4, c_B3
  };
  localparam logic [3:0] c_PUNCH [4] = '{c_G4, c_E4, c_C4, c_REST};

  // Half-period in clk cycles after the simulation shift; never zero.
  function automatic logic [DIV_W-1:0] f_half(input logic [3:0] note);
    logic [31:0] raw;
    case (note)
      c_F3:    raw = 32'd286351;
      c_G3:    raw = 32'd255101;
      c_A3:    raw = 32'd227272;
      c_B3:    raw = 32'd202477;
      c_C4:    raw = 32'd191109;
      c_D4:    raw = 32'd170258;
      c_E4:    raw = 32'd151684;
      c_G4:    raw = 32'd127550;
      default: raw = 32'd0;
    endcase
    raw = raw >> DIV_SHIFT;
    if (raw == 32'd0) raw = 32'd1;
    return DIV_W'(raw);
  endfunction

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_PLAY = 1'b1} state_t;

  state_t              r_state,    w_state_nxt;
  logic                r_pat,      w_pat_nxt;
  logic [4:0]          r_step_idx, w_step_idx_nxt;
  logic [c_SCNT_W-1:0] r_step_cnt, w_step_cnt_nxt;
  logic [DIV_W-1:0]    r_tone_cnt, w_tone_nxt;
  logic                r_speaker,  w_spk_nxt;
  logic                r_busy,     w_busy_nxt;
  logic                r_done,     w_done_nxt;

  logic [3:0]          w_note;
  logic [DIV_W-1:0]    w_half_m1;
  logic [c_SCNT_W-1:0] w_cnt_inc;
  logic                w_last;
  logic                w_step_end;
  logic                w_gate_off;

  assign w_note     = r_pat ? c_PUNCH[r_step_idx[1:0]] : c_MELODY[r_step_idx];
  assign w_half_m1  = f_half(w_note) - DIV_W'(1);
  assign w_cnt_inc  = r_step_cnt + c_SCNT_W'(1);
  assign w_last     = r_pat ? (r_step_idx == 5'd3) : (r_step_idx == 5'd31);
  assign w_step_end = (r_step_cnt == c_STEP_LAST);
  // Gate is judged on the upcoming step count so the speaker drops exactly at GATE_CYCLES.
  assign w_gate_off = (32'(w_cnt_inc) >= GATE_CYCLES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pat      <= 1'b0;
      r_step_idx <= 5'd0;
      r_step_cnt <= '0;
      r_tone_cnt <= '0;
      r_speaker  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pat      <= w_pat_nxt;
      r_step_idx <= w_step_idx_nxt;
      r_step_cnt <= w_step_cnt_nxt;
      r_tone_cnt <= w_tone_nxt;
      r_speaker  <= w_spk_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_pat_nxt      = r_pat;
    w_step_idx_nxt = r_step_idx;
    w_step_cnt_nxt = r_step_cnt;
    w_tone_nxt     = r_tone_cnt;
    w_spk_nxt      = r_speaker;
    w_busy_nxt     = r_busy;
    w_done_nxt     = 1'b0;

    if (bus.stop) begin
      w_state_nxt    = S_IDLE;
      w_step_idx_nxt = 5'd0;
      w_step_cnt_nxt = '0;
      w_tone_nxt     = '0;
      w_spk_nxt      = 1'b0;
      w_busy_nxt     = 1'b0;
    end else if (bus.start) begin
      w_state_nxt    = S_PLAY;
      w_pat_nxt      = bus.pattern_sel;
      w_step_idx_nxt = 5'd0;
      w_step_cnt_nxt = '0;
      w_tone_nxt     = '0;
      w_spk_nxt      = 1'b0;
      w_busy_nxt     = 1'b1;
    end else if (r_state == S_PLAY) begin
      if (w_step_end) begin
        w_step_cnt_nxt = '0;
        w_tone_nxt     = '0;
        w_spk_nxt      = 1'b0;
        if (!w_last) begin
          w_step_idx_nxt = r_step_idx + 5'd1;
        end else if (bus.loop_en) begin
          w_step_idx_nxt = 5'd0;
        end else begin
          w_state_nxt    = S_IDLE;
          w_step_idx_nxt = 5'd0;
          w_busy_nxt     = 1'b0;
          w_done_nxt     = 1'b1;
        end
      end else begin
        w_step_cnt_nxt = w_cnt_inc;
        if (w_gate_off || (w_note == c_REST)) begin
          w_tone_nxt = '0;
          w_spk_nxt  = 1'b0;
        end else if (r_tone_cnt == w_half_m1) begin
          w_tone_nxt = '0;
          w_spk_nxt  = ~r_speaker;
        end else begin
          w_tone_nxt = r_tone_cnt + DIV_W'(1);
        end
      end
    end
  end

  assign bus.speaker  = r_speaker;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.step_idx = r_step_idx;

endmodule
`default_nettype wire
